// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the iFetch instruction memory: packs little-endian bytes into words
// and writes them to consecutive addresses while holding the CPU. Optional checksum: LOADER_CHECKSUM_EN.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef WORD
`define WORD 32
`endif

module instr_mem_loader #(
  parameter int SIZE  = 16,
  parameter int CNT_W = $clog2(SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [CNT_W-1:0]      load_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [`WORD-1:0]      imem_addr,
  output logic [`INSTR_LEN-1:0] imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [IDX_W-1:0]        word_idx_reg;
  logic [1:0]              byte_idx_reg;
  logic [`INSTR_LEN-1:0]   shift_reg;
  logic [`INSTR_LEN-1:0]   word_next;
  logic                    last_word;

  // Current word with the incoming byte merged into its lane.
  always_comb begin
    word_next = shift_reg;
    case (byte_idx_reg)
      2'd0: word_next[7:0]   = byte_data;
      2'd1: word_next[15:8]  = byte_data;
      2'd2: word_next[23:16] = byte_data;
      2'd3: word_next[31:24] = byte_data;
    endcase
  end

  assign last_word = (CNT_W'(word_idx_reg) + CNT_W'(1)) == count_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
`else
  assign load_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg     <= '0;
      load_error   <= 1'b0;
`endif
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (load_start) begin
`ifdef LOADER_CHECKSUM_EN
            load_error <= 1'b0;
            csum_reg   <= '0;
`endif
            cpu_hold <= 1'b1;
            if (load_count == '0) begin
              state_reg <= S_DONE;
              load_done <= 1'b1;
            end else begin
              count_reg    <= (load_count > CNT_W'(SIZE)) ? CNT_W'(SIZE) : load_count;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
              byte_ready   <= 1'b1;
              state_reg    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (byte_valid) begin
            shift_reg    <= word_next;
            byte_idx_reg <= byte_idx_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_reg     <= csum_reg + byte_data;
`endif
            if (byte_idx_reg == 2'd3) begin
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= `WORD'({word_idx_reg, 2'b00});
              imem_wdata <= word_next;
              state_reg  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            state_reg  <= S_CHECK;
`else
            load_done  <= 1'b1;
            state_reg  <= S_DONE;
`endif
          end else begin
            word_idx_reg <= word_idx_reg + IDX_W'(1);
            byte_idx_reg <= '0;
            byte_ready   <= 1'b1;
            state_reg    <= S_COLLECT;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid) begin
            byte_ready <= 1'b0;
            load_error <= (byte_data != csum_reg);
            load_done  <= 1'b1;
            state_reg  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          cpu_hold  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          byte_ready <= 1'b0;
          cpu_hold   <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader with a cycle-level behavioural model
// plus directed scenarios; set LOADER_CHECKSUM_EN to exercise the checksum build.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif
`ifndef WORD
`define WORD 32
`endif

module tb_instr_mem_loader;
  localparam int SIZE  = 16;
  localparam int CNT_W = $clog2(SIZE) + 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  load_start = 1'b0;
  logic [CNT_W-1:0]      load_count = '0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = '0;
  logic                  byte_ready;
  logic                  imem_we;
  logic [`WORD-1:0]      imem_addr;
  logic [`INSTR_LEN-1:0] imem_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  instr_mem_loader #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_count(load_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] wr_log[$];
  logic [7:0]  sent_b[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what a loader obeying the handshake rules must show each cycle.
  bit          m_busy, m_err, exp_we, exp_done;
  int          m_count, m_words, m_nbytes;
  logic [31:0] m_word, exp_addr, exp_data, m_last_addr, m_last_data;
  logic [7:0]  m_sum;

  initial begin
    bit nwe, ndone;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_flags", {59'd0, byte_ready, imem_we, cpu_hold, load_done, load_error}, 64'd0);
        chk("rst_addr_data", {imem_addr, imem_wdata}, 64'd0);
        m_busy = 0; m_err = 0; exp_we = 0; exp_done = 0;
        m_count = 0; m_words = 0; m_nbytes = 0; m_word = 0; m_sum = 0;
        m_last_addr = 0; m_last_data = 0;
      end else begin
        if (imem_we) wr_log.push_back({imem_addr, imem_wdata});
        chk("imem_we", imem_we, exp_we);
        if (exp_we) begin
          chk("imem_addr", imem_addr, exp_addr);
          chk("imem_wdata", imem_wdata, exp_data);
          m_last_addr = exp_addr;
          m_last_data = exp_data;
        end else begin
          chk("addr_hold", imem_addr, m_last_addr);
          chk("wdata_hold", imem_wdata, m_last_data);
        end
        chk("load_done", load_done, exp_done);
        chk("cpu_hold", cpu_hold, m_busy || exp_done);
        chk("byte_ready", byte_ready, m_busy && !exp_we);
        chk("load_error", load_error, m_err);
        nwe = 0; ndone = 0;
        if (!m_busy && !exp_done) begin
          if (load_start) begin
            m_err = 0; m_sum = 0;
            if (load_count == 0) ndone = 1;
            else begin
              m_busy = 1;
              m_count = (load_count > SIZE) ? SIZE : int'(load_count);
              m_words = 0; m_nbytes = 0;
            end
          end
        end else if (m_busy && !exp_we) begin
          if (byte_valid) begin
            if (m_words < m_count) begin
              m_word[8*m_nbytes +: 8] = byte_data;
              m_sum += byte_data;
              m_nbytes++;
              if (m_nbytes == 4) begin
                nwe = 1; exp_addr = 32'(4 * m_words); exp_data = m_word;
                m_words++; m_nbytes = 0;
              end
            end else begin
              m_err = (byte_data != m_sum); m_busy = 0; ndone = 1;
            end
          end
        end else if (m_busy && exp_we && m_words == m_count) begin
`ifndef LOADER_CHECKSUM_EN
          m_busy = 0; ndone = 1;
`endif
        end
        exp_we = nwe; exp_done = ndone;
      end
    end
  end

  task automatic do_start(input int c);
    load_start = 1'b1;
    load_count = CNT_W'(c);
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 100) begin n++; @(negedge clk); end
    if (!byte_ready) chk("byte_timeout", 0, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!load_done && n < 300) begin n++; @(negedge clk); end
    if (!load_done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Random bytes (kept in sent_b), random gaps; optional bad checksum.
  task automatic run_load(input int c, input int gmin, input int gmax, input bit bad);
    int sat;
    logic [7:0] s;
    sat = (c > SIZE) ? SIZE : c;
    s = 0;
    wr_log.delete();
    do_start(c);
    for (int i = 0; i < 4 * sat; i++) begin
      sent_b[i] = 8'($urandom);
      s += sent_b[i];
      send_byte(sent_b[i], int'($urandom_range(gmax, gmin)));
    end
`ifdef LOADER_CHECKSUM_EN
    if (sat > 0) send_byte(bad ? s + 8'd1 : s, 0);
    wait_done();
    chk("csum_error", load_error, (sat > 0) && bad);
`else
    wait_done();
    chk("error_tied", load_error, bad & 1'b0);
`endif
    chk("n_writes", wr_log.size(), sat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1[4];
    t1 = '{8'hC9, 8'h02, 8'h44, 8'hF8};
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", {byte_ready, imem_we, cpu_hold, load_done, load_error}, 0);
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;

    // Test 1: one word, back-to-back bytes
    wr_log.delete();
    do_start(1);
    chk("t1_hold", cpu_hold, 1);
    for (int i = 0; i < 4; i++) send_byte(t1[i], 0);
    chk("t1_we", imem_we, 1);
    chk("t1_addr", imem_addr, 0);
    chk("t1_data", imem_wdata, 32'hF84402C9);
    chk("t1_ready_in_write", byte_ready, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h07, 0);
`else
    @(posedge clk); #1;
`endif
    chk("t1_done", load_done, 1);
    chk("t1_hold_done", cpu_hold, 1);
    chk("t1_err", load_error, 0);
    @(posedge clk); #1;
    chk("t1_done_off", load_done, 0);
    chk("t1_hold_off", cpu_hold, 0);

    // Test 2: three words with two idle cycles before every byte
    run_load(3, 2, 2, 0);
    for (int w = 0; w < 3; w++)
      chk($sformatf("t2_word%0d", w), wr_log[w],
          {32'(4 * w), sent_b[4*w+3], sent_b[4*w+2], sent_b[4*w+1], sent_b[4*w]});

    // Test 3: zero-length load
    wr_log.delete();
    do_start(0);
    chk("t3_done", load_done, 1);
    chk("t3_ready", byte_ready, 0);
    @(posedge clk); #1;
    chk("t3_done_off", load_done, 0);
    chk("t3_writes", wr_log.size(), 0);

    // Test 4: reset in the middle of word 1
    wr_log.delete();
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 0);
    reset = 1'b0;
    #1 chk("t4_flags", {byte_ready, imem_we, cpu_hold, load_done, load_error}, 0);
    chk("t4_addr_data", {imem_addr, imem_wdata}, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    chk("t4_writes", wr_log.size(), 1);
    chk("t4_word0", wr_log[0], {32'd0, 32'h13121110});
    @(posedge clk); #1;
    run_load(1, 0, 1, 0);
    chk("t4_restart_addr", wr_log[0][63:32], 0);

    // Test 5: load_start during a load is ignored
    wr_log.delete();
    do_start(2);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    load_start = 1'b1; load_count = CNT_W'(5);
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(m_sum, 0);
`endif
    wait_done();
    chk("t5_writes", wr_log.size(), 2);

    // Saturation: count above depth loads exactly SIZE words
    run_load(SIZE + 4, 0, 0, 0);
    chk("sat_last_addr", wr_log[SIZE-1][63:32], 4 * (SIZE - 1));

`ifdef LOADER_CHECKSUM_EN
    // Test 6: bad checksum flags a sticky error until the next start
    wr_log.delete();
    do_start(1);
    for (int i = 0; i < 4; i++) send_byte(t1[i], 0);
    send_byte(8'h08, 0);
    wait_done();
    chk("t6_err_set", load_error, 1);
    repeat (3) @(posedge clk);
    #1 chk("t6_err_held", load_error, 1);
    do_start(1);
    chk("t6_err_clear", load_error, 0);
    for (int i = 0; i < 4; i++) send_byte(t1[i], 0);
    send_byte(8'h07, 0);
    wait_done();
    chk("t6_err_good", load_error, 0);
`endif

    for (int k = 0; k < 30; k++)
      run_load(int'($urandom_range(SIZE + 4, 0)), 0, 3, 1'($urandom));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
